// File: rtl/seg7_pkg.sv
// Shared segment patterns for the 7-segment display path.
// Patterns are {g,f,e,d,c,b,a}, active low: a 0 lights the segment.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_A    = 7'b0001000;
  localparam logic [6:0] SEG_B    = 7'b0000011;
  localparam logic [6:0] SEG_C    = 7'b1000110;
  localparam logic [6:0] SEG_D    = 7'b0100001;
  localparam logic [6:0] SEG_E    = 7'b0000110;
  localparam logic [6:0] SEG_F    = 7'b0001110;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Nibble to segment decoder. Hex mode shows 0-F; BCD mode shows a dash
// for any nibble above 9 so an overflowing decade counter is obvious.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_hex_mode,
  output logic [6:0] o_seg
);

  // Map the nibble to its glyph, overriding with a dash for non-BCD values.
  always_comb begin
    // NOTE: default assigned first so every path drives o_seg and no latch is inferred.
    o_seg = SEG_DASH;
    case (i_nibble)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_DASH;
    endcase
    if (!i_hex_mode && (i_nibble > 4'd9)) o_seg = SEG_DASH;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver.
// A slot prescaler selects one digit at a time; inputs are snapshotted once
// per frame so a value never tears across digits. Each slot starts with a
// short all-anodes-off window to hide ghosting while segments settle.
// Until the first snapshot after reset the anodes stay off entirely.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank,
  input  logic                  hex_mode,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);

  localparam logic [CW-1:0]       CNT_MAX   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]       BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0]       IDX_MAX   = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE    = N_DIGITS'(1);

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*N_DIGITS-1:0] r_digits;
  logic [N_DIGITS-1:0]   r_dp_req;
  logic [N_DIGITS-1:0]   r_blank;
  logic                  r_hex;
  logic                  r_lz;
  logic                  r_live;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [N_DIGITS-1:0]   r_an;
  logic                  r_frame_tick;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic [3:0]            w_nib [N_DIGITS];
  logic [N_DIGITS-1:0]   w_lz_dark;
  logic [3:0]            w_cur_nib;
  logic                  w_dark;
  logic [6:0]            w_dec_seg;

  assign w_slot_end  = (r_cnt == CNT_MAX);
  assign w_frame_end = w_slot_end && (r_idx == IDX_MAX);

  // Slot prescaler and scan index; the index steps when the slot counter wraps.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Frame snapshot of all display inputs, loaded only at the frame boundary.
  always_ff @(posedge clk) begin
    // NOTE: the snapshot is plain flops, so it is reset to an all-blank value
    // that makes the first frame dark instead of showing power-up garbage.
    if (rst) begin
      r_digits <= '0;
      r_dp_req <= '0;
      r_blank  <= '1;
      r_hex    <= 1'b0;
      r_lz     <= 1'b0;
      r_live   <= 1'b0;
    end else if (w_frame_end) begin
      r_digits <= digits;
      r_dp_req <= dp_in;
      r_blank  <= blank;
      r_hex    <= hex_mode;
      r_lz     <= lz_en;
      r_live   <= 1'b1;
    end
  end

  // Pulse one cycle after the boundary, i.e. alongside the freshly loaded snapshot.
  always_ff @(posedge clk) begin
    if (rst) r_frame_tick <= 1'b0;
    else     r_frame_tick <= w_frame_end;
  end

  // Leading-zero mask: scan from the top digit down while every nibble is zero.
  always_comb begin
    logic v_run;
    v_run     = 1'b1;
    w_lz_dark = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_nib[i]     = r_digits[4*i +: 4];
      v_run        = v_run && (w_nib[i] == 4'h0);
      w_lz_dark[i] = v_run && (i != 0);
    end
  end

  assign w_cur_nib = w_nib[r_idx];
  assign w_dark    = r_blank[r_idx] || (r_lz && w_lz_dark[r_idx]);

  seg7_decode u_decode (
    .i_nibble   (w_cur_nib),
    .i_hex_mode (r_hex),
    .o_seg      (w_dec_seg)
  );

  // Registered pin drive: anti-ghost window, then the selected digit.
  // Dark digits keep their anode on so every slot draws the same duty cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
      r_an  <= '1;
    end else if (!r_live || (r_cnt < BLANK_END)) begin
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
      r_an  <= '1;
    end else begin
      r_an  <= ~(AN_ONE << r_idx);
      r_seg <= w_dark ? SEG_OFF : w_dec_seg;
      r_dp  <= w_dark || !r_dp_req[r_idx];
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 4-digit, 8-cycle-slot,
// 2-cycle-blank configuration (32-cycle frames). Expected glyphs are
// hand-written constants packed {digit3, digit2, digit1, digit0}.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int TD = 8;
  localparam int BC = 2;

  localparam logic [27:0] G_DARK = {4{7'b1111111}};
  localparam logic [27:0] G_1234 = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
  localparam logic [27:0] G_ABCD = {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001};
  localparam logic [27:0] G_DASH = {4{7'b0111111}};
  localparam logic [27:0] G_0007 = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000};
  localparam logic [27:0] G_0000 = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
  localparam logic [27:0] G_5678 = {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};
  localparam logic [27:0] G_9999 = {4{7'b0010000}};

  logic            clk = 1'b0;
  logic            rst;
  logic [4*N-1:0]  digits;
  logic [N-1:0]    dp_in;
  logic [N-1:0]    blank;
  logic            hex_mode;
  logic            lz_en;
  logic [6:0]      seg;
  logic            dp;
  logic [N-1:0]    an;
  logic            frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  seg7_scan_driver #(
    .N_DIGITS     (N),
    .TICK_DIV     (TD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank      (blank),
    .hex_mode   (hex_mode),
    .lz_en      (lz_en),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk one 32-cycle frame starting from slot state (cnt=0, idx=0).
  // Optionally changes the digits input mid-frame, which must not show.
  task automatic check_frame(input string name, input logic [27:0] exp_seg,
                             input logic [3:0] exp_dp_n, input bit an_on,
                             input bit chg, input logic [15:0] chg_digits);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    int         cnt;
    int         idx;
    for (int j = 0; j < N * TD; j++) begin
      step();
      cnt = j % TD;
      idx = j / TD;
      if (an_on && cnt >= BC) begin
        e_an  = ~(4'b0001 << idx);
        e_seg = exp_seg[idx*7 +: 7];
      end else begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
      end
      check($sformatf("%s_an_j%0d", name, j), 32'(an), 32'(e_an));
      check($sformatf("%s_seg_j%0d", name, j), 32'(seg), 32'(e_seg));
      if (an_on && cnt >= BC)
        check($sformatf("%s_dp_j%0d", name, j), 32'(dp), 32'(exp_dp_n[idx]));
      check($sformatf("%s_ftick_j%0d", name, j), 32'(frame_tick), 32'(j == N * TD - 1));
      if (chg && j == 12) digits = chg_digits;
    end
  endtask

  initial begin
    rst      = 1'b1;
    digits   = 16'h0000;
    dp_in    = 4'b0000;
    blank    = 4'hF;
    hex_mode = 1'b0;
    lz_en    = 1'b0;

    // Reset held for three cycles.
    repeat (3) step();
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'hF);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_ftick", 32'(frame_tick), 32'h0);
    rst = 1'b0;

    // Frame 0: anodes stay off; boundary loads blank=F.
    check_frame("f0_reset", G_DARK, 4'hF, 1'b0, 1'b0, 16'h0);

    // Frame 1: blank snapshot, dark but anodes scanned. Loads 1234.
    digits = 16'h1234;
    blank  = 4'h0;
    check_frame("f1_blank", G_DARK, 4'hF, 1'b1, 1'b0, 16'h0);

    // Frame 2: 1234 in BCD. Loads ABCD hex.
    digits   = 16'hABCD;
    hex_mode = 1'b1;
    check_frame("f2_1234", G_1234, 4'hF, 1'b1, 1'b0, 16'h0);

    // Frame 3: ABCD in hex. Loads ABCD BCD.
    hex_mode = 1'b0;
    check_frame("f3_hex", G_ABCD, 4'hF, 1'b1, 1'b0, 16'h0);

    // Frame 4: dashes. Loads 0007 with LZ.
    digits = 16'h0007;
    lz_en  = 1'b1;
    check_frame("f4_bcd", G_DASH, 4'hF, 1'b1, 1'b0, 16'h0);

    // Frame 5: 0007 with LZ. Loads 0000 with LZ.
    digits = 16'h0000;
    check_frame("f5_lz7", G_0007, 4'hF, 1'b1, 1'b0, 16'h0);

    // Frame 6: all-zero keeps digit 0 lit. Loads 5678 with dp on digit 2.
    digits = 16'h5678;
    lz_en  = 1'b0;
    dp_in  = 4'b0100;
    check_frame("f6_lz0", G_0000, 4'hF, 1'b1, 1'b0, 16'h0);

    // Frame 7: 5678 stays whole while digits change to 9999 mid-frame.
    check_frame("f7_tear", G_5678, 4'b1011, 1'b1, 1'b1, 16'h9999);

    // Frame 8: run to cnt=5, idx=2, then reset mid-slot.
    repeat (21) step();
    check("mid_an", 32'(an), 32'hB);
    check("mid_seg", 32'(seg), 32'(7'b0010000));
    check("mid_dp", 32'(dp), 32'h0);
    rst = 1'b1;
    step();
    check("mrst_seg", 32'(seg), 32'h7F);
    check("mrst_an", 32'(an), 32'hF);
    check("mrst_dp", 32'(dp), 32'h1);
    check("mrst_ftick", 32'(frame_tick), 32'h0);
    rst = 1'b0;

    // Scan restarts at idx 0 with a dark frame, then shows 9999.
    check_frame("f9_rdark", G_DARK, 4'hF, 1'b0, 1'b0, 16'h0);
    check_frame("f10_9999", G_9999, 4'b1011, 1'b1, 1'b0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
